keypad_scan: RTL and testbench

//   Scans a 4x4 matrix keypad: drives one row low at a time, reads active-low columns.

---
 rtl/keypad_pkg.sv | 50 +++++
 rtl/sync_2ff.sv | 33 +++
 rtl/keypad_scan.sv | 136 +++++++++++++
 tb/tb_keypad_scan.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg : shared types, key map and helpers for the 4x4 keypad scanner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] col;
  } onehot_t;

  // Nibble {row,col} holds the legend of that key; row 3 reads E 0 F D.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic onehot_t onehot_low(input logic [3:0] cs);
    onehot_t res;
    res.valid = 1'b1;
    res.col   = 2'd0;
    case (cs)
      4'b1110: res.col = 2'd0;
      4'b1101: res.col = 2'd1;
      4'b1011: res.col = 2'd2;
      4'b0111: res.col = 2'd3;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for asynchronous inputs, resets to all-ones
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ----------------------------------------------------------------------------
// keypad_scan : 4x4 keypad row scanner with press/release debounce and digit pair
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_scan
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV     = 16'd2000,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 16'd1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC - 20'd1);

  logic [3:0]    cs;
  state_t        state_q;
  logic [1:0]    row_q;
  logic [1:0]    col_q;
  logic [3:0]    rows_q;
  logic [SW-1:0] scan_cnt_q;
  logic [DW-1:0] deb_cnt_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [3:0]    digit_new_q;
  logic [3:0]    digit_old_q;

  logic [1:0]    row_d;
  onehot_t       oh_d;
  logic          stable_d;

  sync_2ff #(.W(4)) u_cols_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cols),
    .q_o   (cs)
  );

  assign row_d    = row_q + 2'd1;
  assign oh_d     = onehot_low(cs);
  // The latched key alone must be low; any other column low counts as a deviation.
  assign stable_d = (cs == row_drive(col_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      rows_q      <= 4'b1110;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_q <= '0;
            if (oh_d.valid) begin
              col_q     <= oh_d.col;
              deb_cnt_q <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              row_q  <= row_d;
              rows_q <= row_drive(row_d);
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!stable_d) begin
            deb_cnt_q <= '0;
            row_q     <= row_d;
            rows_q    <= row_drive(row_d);
            state_q   <= SCAN;
          end else if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_q   <= '0;
            key_valid_q <= 1'b1;
            key_code_q  <= key_map(row_q, col_q);
            digit_old_q <= digit_new_q;
            digit_new_q <= key_map(row_q, col_q);
            state_q     <= HELD;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (cs[col_q]) begin
            deb_cnt_q <= '0;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!cs[col_q]) begin
            deb_cnt_q <= '0;
            state_q   <= HELD;
          end else if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_q  <= '0;
            scan_cnt_q <= '0;
            row_q      <= 2'd0;
            rows_q     <= 4'b1110;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign rows      = rows_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ----------------------------------------------------------------------------
// tb_keypad_scan : directed bench for keypad_scan with a passive 4x4 keypad model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scan;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;
  logic [15:0] key_down = '0;

  int n_err  = 0;
  int n_chk  = 0;
  int pulses = 0;
  int p0     = 0;
  logic found;

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; columns idle high.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

  keypad_scan #(
    .SCAN_DIV     (16'd4),
    .DEBOUNCE_CYC (20'd8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    // 1: reset values and free-running row sequence
    cyc(3);
    chk("t1_rows_rst", rows, 4'b1110);
    chk("t1_kv_rst", key_valid, 1'b0);
    chk("t1_code_rst", key_code, 4'h0);
    chk("t1_new_rst", digit_new, 4'h0);
    chk("t1_old_rst", digit_old, 4'h0);
    reset = 1'b0;
    cyc(4); chk("t1_rows_r1", rows, 4'b1101);
    cyc(4); chk("t1_rows_r2", rows, 4'b1011);
    cyc(4); chk("t1_rows_r3", rows, 4'b0111);
    cyc(4); chk("t1_rows_wrap", rows, 4'b1110);

    // 2: hold '5' long, then release
    p0 = pulses;
    key_down[5] = 1'b1;
    cyc(40);
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_code", key_code, 4'h5);
    chk("t2_new", digit_new, 4'h5);
    chk("t2_old", digit_old, 4'h0);
    chk("t2_row_held", rows, 4'b1101);
    key_down[5] = 1'b0;
    cyc(9);  chk("t2_row_rel_hold", rows, 4'b1101);
    cyc(4);  chk("t2_row_rescan", rows, 4'b1110);

    // 3: '5' again, then 'A'
    p0 = pulses;
    key_down[5] = 1'b1; cyc(30); key_down[5] = 1'b0; cyc(30);
    chk("t3_same_new", digit_new, 4'h5);
    chk("t3_same_old", digit_old, 4'h5);
    key_down[3] = 1'b1; cyc(30); key_down[3] = 1'b0; cyc(30);
    chk("t3_pulses", pulses - p0, 2);
    chk("t3_new", digit_new, 4'hA);
    chk("t3_old", digit_old, 4'h5);

    // 4: bouncing '9'
    p0 = pulses;
    key_down[10] = 1'b1; cyc(3);
    key_down[10] = 1'b0; cyc(2);
    key_down[10] = 1'b1; cyc(3);
    chk("t4_no_early_pulse", pulses - p0, 0);
    chk("t4_new_unchanged", digit_new, 4'hA);
    cyc(40);
    chk("t4_pulses", pulses - p0, 1);
    chk("t4_code", key_code, 4'h9);
    key_down[10] = 1'b0; cyc(20);

    // 5: '1' and '3' together in row 0, then only '1'
    p0 = pulses;
    key_down[0] = 1'b1; key_down[2] = 1'b1;
    cyc(40);
    chk("t5_no_pulse", pulses - p0, 0);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (rows == 4'b1101) found = 1'b1;
    end
    chk("t5_still_scanning", found, 1'b1);
    key_down[2] = 1'b0;
    cyc(40);
    chk("t5_pulses", pulses - p0, 1);
    chk("t5_code", key_code, 4'h1);
    key_down[0] = 1'b0; cyc(20);

    // 6: reset while 'D' is held
    p0 = pulses;
    key_down[15] = 1'b1;
    cyc(40);
    chk("t6_pulse_pre", pulses - p0, 1);
    chk("t6_code_pre", key_code, 4'hD);
    reset = 1'b1;
    cyc(1);
    chk("t6_rows_rst", rows, 4'b1110);
    chk("t6_kv_rst", key_valid, 1'b0);
    chk("t6_code_rst", key_code, 4'h0);
    chk("t6_new_rst", digit_new, 4'h0);
    chk("t6_old_rst", digit_old, 4'h0);
    cyc(1);
    reset = 1'b0;
    p0 = pulses;
    cyc(40);
    chk("t6_pulse_post", pulses - p0, 1);
    chk("t6_code_post", key_code, 4'hD);
    chk("t6_new_post", digit_new, 4'hD);
    chk("t6_old_post", digit_old, 4'h0);
    key_down[15] = 1'b0;
    cyc(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
